// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler:
// FSM state encoding, status-word bit positions and default sizing.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } sched_state_t;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    localparam int DEF_DEPTH      = 8;
    localparam int DEF_GAP_CYCLES = 2;

endpackage

// File: rtl/byte_fifo.sv
// Byte queue with registered count; full/empty come from the count only.
// flush wins over push and pop in the same cycle.
module byte_fifo
    import uart_sched_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = pop && !empty && !flush;
    // A pop in the same cycle frees the slot a full queue would otherwise refuse.
    assign w_do_push = push && (!full || w_do_pop) && !flush;
    assign dout      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues core stores to the UART TX address and feeds the transmitter one
// byte at a time, with an idle gap after each completed frame.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             flush,
    input  logic             tx_done,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             busy,
    output logic             overflow,
    output logic [31:0]      status_word
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic             r_tx_start;
    logic [7:0]       r_tx_data;
    logic             r_busy;
    logic             r_overflow;
    logic             w_pop;
    logic [7:0]       w_fifo_dout;

    byte_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (w_pop),
        .flush (flush),
        .din   (wr_data),
        .dout  (w_fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                // A flush in the pop cycle suppresses the pop and keeps us in IDLE.
                if (!empty && !flush) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: w_state_nxt = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = GAP;
                        w_gap_nxt   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gap_cnt  <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_tx_start <= w_pop;
            r_busy     <= (w_state_nxt != IDLE);
            if (w_pop) begin
                r_tx_data <= w_fifo_dout;
            end
            if (flush) begin
                r_overflow <= 1'b0;
            end else if (wr_en && full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign busy     = r_busy;
    assign overflow = r_overflow;

    always_comb begin
        status_word                        = '0;
        status_word[ST_CNT_LSB +: CNT_W]   = count;
        status_word[ST_OVF]                = r_overflow;
        status_word[ST_BUSY]               = r_busy;
        status_word[ST_FULL]               = full;
        status_word[ST_EMPTY]              = empty;
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based model of the scheduler.
module tb_uart_tx_scheduler;
    localparam int DEPTH = 8;
    localparam int GAP   = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             flush = 1'b0;
    logic             tx_done = 1'b0;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             busy;
    logic             overflow;
    logic [31:0]      status_word;

    uart_tx_scheduler #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .tx_done     (tx_done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .busy        (busy),
        .overflow    (overflow),
        .status_word (status_word)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a byte queue, a "frame in flight" flag and a hold-off
    // count of cycles after a completed frame during which no pop may happen.
    byte unsigned m_q[$];
    bit           m_inflight = 1'b0;
    bit           m_start    = 1'b0;
    bit           m_ovf      = 1'b0;
    int           m_hold     = 0;
    logic [7:0]   m_txd      = 8'h00;

    // Transmitter responder
    bit           resp_en  = 1'b0;
    int           resp_cnt = 0;
    int           resp_lo  = 10;
    int           resp_hi  = 10;
    int           spur_pct = 0;
    byte unsigned sent[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit wr, input logic [7:0] din,
                              input bit fl, input bit done);
        bit can_pop;
        bit done_ok;
        if (rst) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_start    = 1'b0;
            m_hold     = 0;
            m_txd      = 8'h00;
            m_ovf      = 1'b0;
            return;
        end
        can_pop = !m_inflight && (m_hold == 0) && (m_q.size() != 0) && !fl;
        // The transmitter cannot finish during the cycle it is being started.
        done_ok = m_inflight && !m_start && done;
        if (fl) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (can_pop) m_txd = m_q.pop_front();
            if (wr) begin
                if (m_q.size() < DEPTH) m_q.push_back(din);
                else m_ovf = 1'b1;
            end
        end
        if (done_ok) begin
            m_inflight = 1'b0;
            m_hold     = GAP;
        end else if (m_hold > 0) begin
            m_hold--;
        end
        if (can_pop) m_inflight = 1'b1;
        m_start = can_pop;
    endtask

    task automatic compare_all();
        logic [31:0] exp_sw;
        bit          exp_busy;
        bit          exp_empty;
        bit          exp_full;
        exp_busy  = m_inflight || (m_hold > 0);
        exp_empty = (m_q.size() == 0);
        exp_full  = (m_q.size() == DEPTH);
        exp_sw    = (32'(m_q.size()) << 8) | (32'(m_ovf) << 3) | (32'(exp_busy) << 2)
                  | (32'(exp_full) << 1) | 32'(exp_empty);
        check_eq("tx_start", 32'(tx_start), 32'(m_start));
        check_eq("tx_data", 32'(tx_data), 32'(m_txd));
        check_eq("count", 32'(count), 32'(m_q.size()));
        check_eq("empty", 32'(empty), 32'(exp_empty));
        check_eq("full", 32'(full), 32'(exp_full));
        check_eq("busy", 32'(busy), 32'(exp_busy));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("status_word", status_word, exp_sw);
    endtask

    task automatic step(input bit rst, input bit wr, input logic [7:0] din,
                        input bit fl, input bit force_done);
        bit done;
        done = force_done || (resp_en && resp_cnt == 1) || ($urandom_range(99) < spur_pct);
        if (resp_cnt > 0) resp_cnt--;
        reset   = rst;
        wr_en   = wr;
        wr_data = din;
        flush   = fl;
        tx_done = done;
        @(posedge clk);
        model_edge(rst, wr, din, fl, done);
        #1;
        compare_all();
        if (tx_start) begin
            sent.push_back(tx_data);
            resp_cnt = $urandom_range(resp_hi, resp_lo);
        end
        if (rst) resp_cnt = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        byte unsigned exp_seq[$];

        // Reset and quiet idle
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(5);
        check_eq("idle_status", status_word, 32'h0000_0001);

        // Single byte, transmitter answers 10 cycles after start
        resp_en = 1'b1;
        sent.delete();
        step(1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
        idle(20);
        check_eq("t2_nsent", 32'(sent.size()), 32'd1);
        if (sent.size() == 1) check_eq("t2_byte", 32'(sent[0]), 32'h41);

        // Overflow: one frame held in flight while the queue fills past DEPTH
        resp_en = 1'b0;
        sent.delete();
        step(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        check_eq("t3_full", 32'(full), 32'd1);
        step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        check_eq("t3_ovf", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        resp_en = 1'b1;
        resp_lo = 3;
        resp_hi = 6;
        idle(120);
        exp_seq = '{8'h20, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
        check_eq("t3_nsent", 32'(sent.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < sent.size(); i++)
            check_eq("t3_order", 32'(sent[i]), 32'(exp_seq[i]));

        // Full queue with push and pop in the same cycle, drained across the wrap
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        resp_en = 1'b0;
        sent.delete();
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        check_eq("t4_full", 32'(count), 32'd8);
        step(1'b0, 1'b1, 8'h60, 1'b0, 1'b1);
        for (int i = 1; i <= GAP + 1; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        check_eq("t4_count_held", 32'(count), 32'd8);
        resp_en = 1'b1;
        idle(120);
        exp_seq = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h63};
        check_eq("t4_nsent", 32'(sent.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < sent.size(); i++)
            check_eq("t4_order", 32'(sent[i]), 32'(exp_seq[i]));

        // Flush while a frame is in flight with 3 bytes queued
        resp_en = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
        idle(2);
        check_eq("t5_queued", 32'(count), 32'd3);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t5_flushed", 32'(count), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        sent.delete();
        idle(10);
        check_eq("t5_nsent", 32'(sent.size()), 32'd0);

        // Reset during WAIT, then a stale tx_done
        step(1'b0, 1'b1, 8'hB1, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(4);
        check_eq("t6_status", status_word, 32'h0000_0001);

        // Randomized traffic
        resp_en  = 1'b1;
        resp_lo  = 1;
        resp_hi  = 6;
        spur_pct = 3;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(999) < 3), ($urandom_range(99) < 45), 8'($urandom),
                 ($urandom_range(99) < 1), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
